data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's data-memory request/acknowledge interface: a word-organised RAM
//  with a programmable number of wait states. It answers level-held read/write requests from the
//  control path by pulsing data_available (reads) or request_successful (writes) after LATENCY
//  cycles. Used as the stalling data memory in single-cycle simulation and FPGA top levels.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; storage = 2**ADDR_WIDTH 32-bit words
//  LATENCY     2   cycles from request acceptance to acknowledge; legal range 1..15
// PORTS
//  clock               in   1   rising-edge clock
//  reset               in   1   asynchronous, active-high reset
//  address             in   32  byte address; bits [1:0] ignored, [ADDR_WIDTH+1:2] index word
//  read_enable         in   1   read request, held high until acknowledged or abandoned
//  write_enable        in   1   write request, held high until acknowledged or abandoned
//  write_data          in   32  store data, byte-lane aligned
//  write_mask          in   4   byte enables for write_data, bit i = byte lane i
//  read_data           out  32  registered read word, valid while data_available=1
//  data_available      out  1   read acknowledge, one-cycle pulse
//  request_successful  out  1   write acknowledge, one-cycle pulse
//  busy                out  1   high in WAIT or RESP
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, counter=0, read_data=0, both acks=0, busy=0;
//    RAM contents not reset; an in-flight write is dropped (RAM unchanged).
//  - req = read_enable | write_enable. FSM IDLE/WAIT/RESP, 4-bit down-counter.
//  - IDLE: on req, capture address, write_data, write_mask, type (write wins if both high);
//    LATENCY=1 -> RESP, else counter<=LATENCY-1 and -> WAIT.
//  - WAIT: req low -> IDLE (abandoned, no side effects). Else counter decrements; on the edge
//    where counter==1 -> RESP and, for reads, read_data<=RAM[captured index].
//  - RESP: data_available = read type & read_enable; request_successful = write type & write_enable
//    (combinational from state + live enable; low if request dropped). On leaving RESP, a write
//    with write_enable still high updates only the masked bytes. Always -> IDLE next edge.
//  - Latency: request first seen high at edge N (IDLE) -> ack high in cycle N+LATENCY, exactly one cycle.
//  - Back-to-back: a request held/re-asserted the cycle after RESP is treated as new (IDLE acceptance);
//    minimum spacing between acks = LATENCY+1 cycles. A request is never acked twice.
//  - Address/data changes after acceptance are ignored (captured values used).
//  - Address aliasing: bits above ADDR_WIDTH+1 ignored; index wraps modulo 2**ADDR_WIDTH.
//  - Both enables high: treated as a write; request_successful pulses, data_available stays 0.
//  - read_data holds its last value outside RESP; a read returns the RAM word as of entry to RESP
//    (a write acked in the same RESP cannot occur, since one request is serviced at a time).
//  - Acknowledge outputs never asserted outside RESP; busy = (state != IDLE).
// TESTING
//  1. Reset then read addr 0x0000_0010 with RAM[4]=0xDEADBEEF, LATENCY=2 -> data_available high
//     exactly 2 cycles after acceptance for 1 cycle, read_data=0xDEADBEEF.
//  2. Write 0x11223344 mask 4'b0101 to 0x20 over RAM[8]=0xAABBCCDD -> request_successful 1-cycle
//     pulse; subsequent read of 0x20 returns 0xAA22CC44.
//  3. Write request dropped in WAIT -> no ack, RAM[index] unchanged, IDLE next cycle, busy=0.
//  4. reset asserted mid-WAIT of a write -> outputs 0 immediately, no write, fresh read then succeeds.
//  5. Read held continuously for 10 cycles, LATENCY=2 -> acks at cycles 2,5,8 only; none doubled.
//  6. LATENCY=1, ADDR_WIDTH=4: read 0x40 after writing 0x0 -> aliases word 0, ack 1 cycle after acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering level-held read/write requests after a
// programmable number of wait states, acknowledging with one-cycle pulses.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic [31:0] read_data,
  output logic        data_available,
  output logic        request_successful,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LatCount = 4'(LATENCY - 1);

  logic [31:0] mem [2**ADDR_WIDTH];

  state_t                state_q, state_d;
  logic [3:0]            counter_q, counter_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic                  isWrite_q, isWrite_d;
  logic [31:0]           readData_q, readData_d;

  logic                  req;
  logic [ADDR_WIDTH-1:0] addrIdx;
  logic                  memWrite;

  assign req     = read_enable | write_enable;
  assign addrIdx = address[ADDR_WIDTH+1:2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      isWrite_q  <= 1'b0;
      readData_q <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      isWrite_q  <= isWrite_d;
      readData_q <= readData_d;
    end
  end

  // Request fields are captured once at acceptance; later input changes are ignored.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    isWrite_d  = isWrite_q;
    readData_d = readData_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d     = addrIdx;
          wdata_d   = write_data;
          wmask_d   = write_mask;
          isWrite_d = write_enable;
          if (LATENCY == 1) begin
            state_d = RESP;
            if (!write_enable) readData_d = mem[addrIdx];
          end else begin
            counter_d = LatCount;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d   = IDLE;
          counter_d = '0;
        end else begin
          counter_d = counter_q - 4'd1;
          if (counter_q == 4'd1) begin
            state_d = RESP;
            if (!isWrite_q) readData_d = mem[idx_q];
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The store commits on the edge that leaves RESP, and only if the requester still holds it.
  assign memWrite = (state_q == RESP) && isWrite_q && write_enable && !reset;

  always_ff @(posedge clock) begin
    if (memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign read_data          = readData_q;
  assign data_available     = (state_q == RESP) && !isWrite_q && read_enable;
  assign request_successful = (state_q == RESP) && isWrite_q && write_enable;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a latency-2 / 1K-word instance and a
// latency-1 / 16-word instance driven from cycle-by-cycle vector tables.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] address, writeData, readData;
  logic        readEnable, writeEnable, dataAvailable, requestSuccessful, busy;
  logic [3:0]  writeMask;

  logic [31:0] address2, writeData2, readData2;
  logic        readEnable2, writeEnable2, dataAvailable2, requestSuccessful2, busy2;
  logic [3:0]  writeMask2;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .address(address),
    .read_enable(readEnable), .write_enable(writeEnable),
    .write_data(writeData), .write_mask(writeMask), .read_data(readData),
    .data_available(dataAvailable), .request_successful(requestSuccessful), .busy(busy)
  );

  data_mem_responder #(.ADDR_WIDTH(4), .LATENCY(1)) dut2 (
    .clock(clock), .reset(reset), .address(address2),
    .read_enable(readEnable2), .write_enable(writeEnable2),
    .write_data(writeData2), .write_mask(writeMask2), .read_data(readData2),
    .data_available(dataAvailable2), .request_successful(requestSuccessful2), .busy(busy2)
  );

  typedef struct {
    string       name;
    bit          sel;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        expAvail;
    logic        expSucc;
    logic        expBusy;
    bit          chkData;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[$];

  function automatic void addRow(string name, bit sel, logic re, logic we,
                                 logic [31:0] addr, logic [31:0] wdata, logic [3:0] mask,
                                 logic ea, logic es, logic eb, bit cd, logic [31:0] ed);
    vec_t v;
    v.name = name; v.sel = sel; v.re = re; v.we = we; v.addr = addr;
    v.wdata = wdata; v.mask = mask; v.expAvail = ea; v.expSucc = es;
    v.expBusy = eb; v.chkData = cd; v.expData = ed;
    vecs.push_back(v);
  endfunction

  // One write transaction: wait rows, ack row, commit row (enable still held), idle row.
  function automatic void addWrite(string name, bit sel, logic [31:0] addr, logic [31:0] data,
                                   logic [3:0] mask, int lat, logic alsoRead);
    for (int i = 1; i < lat; i++)
      addRow({name, " wait"}, sel, alsoRead, 1'b1, addr, data, mask, 0, 0, 1, 0, '0);
    addRow({name, " ack"}, sel, alsoRead, 1'b1, addr, data, mask, 0, 1, 1, 0, '0);
    addRow({name, " commit"}, sel, alsoRead, 1'b1, addr, data, mask, 0, 0, 0, 0, '0);
    addRow({name, " idle"}, sel, 1'b0, 1'b0, '0, '0, '0, 0, 0, 0, 0, '0);
  endfunction

  // One read transaction; the address switches to addrLater after the acceptance row.
  function automatic void addRead(string name, bit sel, logic [31:0] addr, logic [31:0] addrLater,
                                  logic [31:0] exp, int lat);
    for (int i = 0; i < lat; i++) begin
      if (i == lat - 1)
        addRow({name, " ack"}, sel, 1'b1, 1'b0, (i == 0) ? addr : addrLater, '0, '0, 1, 0, 1, 1, exp);
      else
        addRow({name, " wait"}, sel, 1'b1, 1'b0, (i == 0) ? addr : addrLater, '0, '0, 0, 0, 1, 0, '0);
    end
    addRow({name, " release"}, sel, 1'b1, 1'b0, addrLater, '0, '0, 0, 0, 0, 1, exp);
    addRow({name, " hold"}, sel, 1'b0, 1'b0, '0, '0, '0, 0, 0, 0, 1, exp);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic driveIdle();
    readEnable = 0; writeEnable = 0; address = '0; writeData = '0; writeMask = '0;
    readEnable2 = 0; writeEnable2 = 0; address2 = '0; writeData2 = '0; writeMask2 = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(vec_t v);
    driveIdle();
    if (v.sel) begin
      readEnable2 = v.re; writeEnable2 = v.we; address2 = v.addr;
      writeData2 = v.wdata; writeMask2 = v.mask;
    end else begin
      readEnable = v.re; writeEnable = v.we; address = v.addr;
      writeData = v.wdata; writeMask = v.mask;
    end
    step();
    if (v.sel) begin
      checkOutput({v.name, " avail"}, 32'(dataAvailable2), 32'(v.expAvail));
      checkOutput({v.name, " succ"}, 32'(requestSuccessful2), 32'(v.expSucc));
      checkOutput({v.name, " busy"}, 32'(busy2), 32'(v.expBusy));
      if (v.chkData) checkOutput({v.name, " data"}, readData2, v.expData);
    end else begin
      checkOutput({v.name, " avail"}, 32'(dataAvailable), 32'(v.expAvail));
      checkOutput({v.name, " succ"}, 32'(requestSuccessful), 32'(v.expSucc));
      checkOutput({v.name, " busy"}, 32'(busy), 32'(v.expBusy));
      if (v.chkData) checkOutput({v.name, " data"}, readData, v.expData);
    end
  endtask

  task automatic runRows();
    foreach (vecs[i]) applyStimulus(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] availBits;

    driveIdle();

    addWrite("fill 0x10", 0, 32'h10, 32'hDEADBEEF, 4'hF, 2, 1'b0);
    addRead("read 0x10", 0, 32'h10, 32'h20, 32'hDEADBEEF, 2);
    addWrite("fill 0x20", 0, 32'h20, 32'hAABBCCDD, 4'hF, 2, 1'b0);
    addWrite("masked 0x20", 0, 32'h20, 32'h11223344, 4'b0101, 2, 1'b0);
    addRead("read 0x20", 0, 32'h20, 32'h20, 32'hAA22CC44, 2);
    addWrite("both en 0x1030", 0, 32'h1030, 32'h12345678, 4'hF, 2, 1'b1);
    addRead("alias 0xFFFFF030", 0, 32'hFFFF_F030, 32'h0, 32'h12345678, 2);
    addRead("alias 0x80001033", 0, 32'h8000_1033, 32'h0, 32'h12345678, 2);
    addWrite("l1 fill 0x0", 1, 32'h0, 32'hCAFEF00D, 4'hF, 1, 1'b0);
    addWrite("l1 fill 0x4", 1, 32'h4, 32'h11111111, 4'hF, 1, 1'b0);
    addRead("l1 alias 0x40", 1, 32'h40, 32'h40, 32'hCAFEF00D, 1);
    addRead("l1 alias 0x44", 1, 32'h44, 32'h44, 32'h11111111, 1);

    #12;
    checkOutput("reset avail", 32'(dataAvailable), 32'h0);
    checkOutput("reset succ", 32'(requestSuccessful), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset data", readData, 32'h0);
    checkOutput("reset busy2", 32'(busy2), 32'h0);
    reset = 0;
    step();

    runRows();

    // Write abandoned in WAIT: no ack, no store.
    driveIdle();
    writeEnable = 1; address = 32'h20; writeData = 32'h0; writeMask = 4'hF;
    step();
    checkOutput("drop busy in wait", 32'(busy), 32'h1);
    writeEnable = 0;
    step();
    checkOutput("drop busy after", 32'(busy), 32'h0);
    checkOutput("drop succ", 32'(requestSuccessful), 32'h0);
    addRead("after drop", 0, 32'h20, 32'h20, 32'hAA22CC44, 2);
    runRows();

    // Reset in the middle of a write wait.
    writeEnable = 1; address = 32'h20; writeData = 32'hFFFFFFFF; writeMask = 4'hF;
    step();
    checkOutput("rst write busy", 32'(busy), 32'h1);
    #2 reset = 1;
    #1;
    checkOutput("rst busy", 32'(busy), 32'h0);
    checkOutput("rst succ", 32'(requestSuccessful), 32'h0);
    checkOutput("rst avail", 32'(dataAvailable), 32'h0);
    checkOutput("rst data", readData, 32'h0);
    writeEnable = 0;
    @(negedge clock);
    reset = 0;
    step();
    addRead("after reset", 0, 32'h20, 32'h20, 32'hAA22CC44, 2);
    runRows();

    // Read held for ten edges: acknowledges after edges 2, 5 and 8 only.
    driveIdle();
    readEnable = 1; address = 32'h10;
    availBits = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      availBits[k-1] = dataAvailable;
      if (dataAvailable) checkOutput($sformatf("held read data %0d", k), readData, 32'hDEADBEEF);
    end
    checkOutput("held read ack pattern", 32'(availBits), 32'h092);
    readEnable = 0;
    step();
    checkOutput("held read release busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
